// File: rtl/matmul_scratchpad_if.sv
// Bundles the engine request port, the host load/unload port and the error flag
// shared by the scratchpad and its requesters.
interface matmul_scratchpad_if #(
  parameter int TYPE_BW = 32
);
  logic [1:0]         mem_operation;
  logic [31:0]        mem_addr;
  logic [TYPE_BW-1:0] mem_wdata;
  logic [TYPE_BW-1:0] mem_rdata;
  logic               mem_opdone;
  logic               host_req;
  logic               host_we;
  logic [31:0]        host_addr;
  logic [TYPE_BW-1:0] host_wdata;
  logic [TYPE_BW-1:0] host_rdata;
  logic               host_ack;
  logic               addr_err;

  modport master (
    output mem_operation, mem_addr, mem_wdata,
    output host_req, host_we, host_addr, host_wdata,
    input  mem_rdata, mem_opdone, host_rdata, host_ack, addr_err
  );

  modport slave (
    input  mem_operation, mem_addr, mem_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    output mem_rdata, mem_opdone, host_rdata, host_ack, addr_err
  );
endinterface

// File: rtl/matmul_scratchpad.sv
// Single-ported word scratchpad shared by the matmul engine and a host port,
// round-robin arbitrated, one access every four cycles.
module matmul_scratchpad #(
  parameter int TYPE_BW = 32,
  parameter int DEPTH   = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  matmul_scratchpad_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, GAP} state_t;

  state_t             r_state;
  logic               r_grant_host;
  logic               r_last_host;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [TYPE_BW-1:0] r_wdata;
  logic [TYPE_BW-1:0] r_mem_rdata;
  logic [TYPE_BW-1:0] r_host_rdata;
  logic               r_mem_opdone;
  logic               r_host_ack;
  logic               r_addr_err;
  logic [TYPE_BW-1:0] r_mem [DEPTH];

  logic               w_eng_req;
  logic               w_pick_host;
  logic               w_in_range;
  logic [AW-1:0]      w_idx;
  logic [TYPE_BW-1:0] w_rd_val;

  // Host wins only when the engine is idle or the engine held the last grant.
  assign w_eng_req   = bus.mem_operation[0];
  assign w_pick_host = bus.host_req && (!w_eng_req || !r_last_host);
  assign w_in_range  = (r_addr < 32'(DEPTH));
  assign w_idx       = r_addr[AW-1:0];
  assign w_rd_val    = w_in_range ? r_mem[w_idx] : '0;

  assign bus.mem_rdata  = r_mem_rdata;
  assign bus.mem_opdone = r_mem_opdone;
  assign bus.host_rdata = r_host_rdata;
  assign bus.host_ack   = r_host_ack;
  assign bus.addr_err   = r_addr_err;

  always_ff @(posedge clk) begin
    if (r_state == ACCESS && r_we && w_in_range)
      r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant_host <= 1'b0;
      r_last_host  <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_rdata  <= '0;
      r_host_rdata <= '0;
      r_mem_opdone <= 1'b0;
      r_host_ack   <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_mem_opdone <= 1'b0;
      r_host_ack   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_eng_req || bus.host_req) begin
            r_grant_host <= w_pick_host;
            r_last_host  <= w_pick_host;
            r_we         <= w_pick_host ? bus.host_we    : bus.mem_operation[1];
            r_addr       <= w_pick_host ? bus.host_addr  : bus.mem_addr;
            r_wdata      <= w_pick_host ? bus.host_wdata : bus.mem_wdata;
            r_state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!w_in_range)
            r_addr_err <= 1'b1;
          if (!r_we) begin
            if (r_grant_host)
              r_host_rdata <= w_rd_val;
            else
              r_mem_rdata <= w_rd_val;
          end
          if (r_grant_host)
            r_host_ack <= 1'b1;
          else
            r_mem_opdone <= 1'b1;
          r_state <= DONE;
        end
        DONE:    r_state <= GAP;
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
